// File: rtl/rsp_s1_prep_ahb_dec.sv
// AHB-lite decoder / response mux for the rsp_s1_prep register fabric.
// Adds a default error slave, a per-transfer wait-state timeout and sticky error status.
module rsp_s1_prep_ahb_dec #(
    parameter int unsigned       N_CH      = 7,
    parameter int unsigned       AHB_DW    = 32,
    parameter int unsigned       AHB_AW    = 32,
    parameter int unsigned       CH_AW     = 10,
    parameter logic [AHB_AW-1:0] BASE_ADDR = 'h4000_0000,
    parameter int unsigned       TO_CYC    = 256
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic                     hsel,
    input  logic [1:0]               htrans,
    input  logic [AHB_AW-1:0]        haddr,
    input  logic [2:0]               hburst,
    input  logic [2:0]               hsize,
    input  logic [AHB_DW-1:0]        hwdata,
    input  logic                     hwrite,
    input  logic                     hreadyin,
    output logic [AHB_DW-1:0]        hrdata,
    output logic [1:0]               hresp,
    output logic                     hready,
    output logic [N_CH-1:0]          ch_hsel,
    output logic [N_CH*2-1:0]        ch_htrans,
    output logic [N_CH*AHB_AW-1:0]   ch_haddr,
    output logic [N_CH*3-1:0]        ch_hburst,
    output logic [N_CH*3-1:0]        ch_hsize,
    output logic [N_CH*AHB_DW-1:0]   ch_hwdata,
    output logic [N_CH-1:0]          ch_hwrite,
    output logic [N_CH-1:0]          ch_hreadyin,
    input  logic [N_CH*AHB_DW-1:0]   ch_hrdata,
    input  logic [N_CH*2-1:0]        ch_hresp,
    input  logic [N_CH-1:0]          ch_hready,
    output logic                     to_err,
    output logic [N_CH-1:0]          hung,
    output logic [15:0]              err_cnt
);

    localparam int unsigned SELW   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned HI_LSB = CH_AW + SELW;
    localparam int unsigned NPAD   = 1 << SELW;
    localparam int unsigned TOW    = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [AHB_AW-1:0] OFF_MASK = AHB_AW'((64'd1 << CH_AW) - 64'd1);

    typedef enum logic [1:0] {S_IDLE, S_CH, S_ERR1, S_ERR2} state_t;

    state_t            state, state_nxt, ld_state;
    logic [SELW-1:0]   cur_ch, ch_nxt;
    logic [SELW-1:0]   idx;
    logic [NPAD-1:0]   hung_pad;
    logic              base_match, hit, accept, timeout, to_hit;
    logic [TOW-1:0]    to_cnt;
    logic [AHB_DW-1:0] sel_rdata;
    logic [1:0]        sel_resp;
    logic              sel_ready;

    // Address decode: window select plus hung-channel masking
    assign idx      = haddr[CH_AW +: SELW];
    assign hung_pad = NPAD'(hung);

    generate
        if (HI_LSB < AHB_AW) begin : g_base
            assign base_match = (haddr[AHB_AW-1:HI_LSB] == BASE_ADDR[AHB_AW-1:HI_LSB]);
        end else begin : g_nobase
            assign base_match = 1'b1;
        end
    endgenerate

    assign hit      = base_match & (32'(idx) < N_CH) & ~hung_pad[idx];
    assign accept   = hsel & htrans[1] & hreadyin;
    assign ld_state = !accept ? S_IDLE : (hit ? S_CH : S_ERR1);
    assign to_hit   = (TO_CYC != 0) && (32'(to_cnt) == TO_CYC - 1);

    // Combinational fan-out to every channel lane
    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_lane
            assign ch_hsel[i]                      = hsel & hit & (idx == SELW'(i));
            assign ch_htrans[i*2 +: 2]             = htrans;
            assign ch_haddr[i*AHB_AW +: AHB_AW]    = haddr & OFF_MASK;
            assign ch_hburst[i*3 +: 3]             = hburst;
            assign ch_hsize[i*3 +: 3]              = hsize;
            assign ch_hwdata[i*AHB_DW +: AHB_DW]   = hwdata;
            assign ch_hwrite[i]                    = hwrite;
            assign ch_hreadyin[i]                  = hreadyin;
        end
    endgenerate

    // Response of the lane owning the current data phase
    always_comb begin
        sel_rdata = '0;
        sel_resp  = 2'b00;
        sel_ready = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (cur_ch == SELW'(i)) begin
                sel_rdata = ch_hrdata[i*AHB_DW +: AHB_DW];
                sel_resp  = ch_hresp[i*2 +: 2];
                sel_ready = ch_hready[i];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state  <= S_IDLE;
            cur_ch <= '0;
        end else begin
            state  <= state_nxt;
            cur_ch <= ch_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ch_nxt    = cur_ch;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = ld_state;
                ch_nxt    = idx;
            end
            S_CH: begin
                if (sel_ready) begin
                    state_nxt = ld_state;
                    ch_nxt    = idx;
                end else if (to_hit) begin
                    state_nxt = S_ERR1;
                    timeout   = 1'b1;
                end
            end
            S_ERR1: state_nxt = S_ERR2;
            S_ERR2: begin
                state_nxt = ld_state;
                ch_nxt    = idx;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        hready = 1'b1;
        hresp  = 2'b00;
        hrdata = '0;
        case (state)
            S_CH: begin
                hready = sel_ready;
                hresp  = sel_resp;
                hrdata = sel_rdata;
            end
            S_ERR1: begin
                hready = 1'b0;
                hresp  = 2'b01;
            end
            S_ERR2: hresp = 2'b01;
            default: ;
        endcase
    end

    // Wait-state counter, hung flags and error statistics
    always_ff @(posedge hclk) begin
        if (hreset) begin
            to_cnt  <= '0;
            to_err  <= 1'b0;
            hung    <= '0;
            err_cnt <= '0;
        end else begin
            to_cnt <= (state == S_CH && !sel_ready) ? to_cnt + TOW'(1) : '0;
            to_err <= timeout;
            for (int i = 0; i < N_CH; i++) begin
                if (timeout && cur_ch == SELW'(i))
                    hung[i] <= 1'b1;
                else if (ch_hready[i] && !(state == S_CH && cur_ch == SELW'(i)))
                    hung[i] <= 1'b0;
            end
            if (state == S_ERR2 && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rsp_s1_prep_ahb_dec.sv
// Randomized self-checking bench for rsp_s1_prep_ahb_dec against a transaction-level
// model of decode windows, wait states, timeout aborts and sticky status.
module tb_rsp_s1_prep_ahb_dec;

    localparam int unsigned N_CH   = 7;
    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 32;
    localparam int unsigned CH_AW  = 10;
    localparam int unsigned TO_CYC = 8;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam longint      WIN    = 1024;

    logic               hclk = 1'b0;
    logic               hreset, hsel, hwrite, hreadyin;
    logic [1:0]         htrans;
    logic [AW-1:0]      haddr;
    logic [2:0]         hburst, hsize;
    logic [DW-1:0]      hwdata;
    logic [DW-1:0]      hrdata;
    logic [1:0]         hresp;
    logic               hready;
    logic [N_CH-1:0]    ch_hsel, ch_hwrite, ch_hreadyin, ch_hready;
    logic [N_CH*2-1:0]  ch_htrans, ch_hresp;
    logic [N_CH*AW-1:0] ch_haddr;
    logic [N_CH*3-1:0]  ch_hburst, ch_hsize;
    logic [N_CH*DW-1:0] ch_hwdata, ch_hrdata;
    logic               to_err;
    logic [N_CH-1:0]    hung;
    logic [15:0]        err_cnt;

    int                 n_checks, n_errors;
    logic [N_CH-1:0]    hung_m;
    logic [15:0]        err_m;

    rsp_s1_prep_ahb_dec #(
        .N_CH(N_CH), .AHB_DW(DW), .AHB_AW(AW), .CH_AW(CH_AW),
        .BASE_ADDR(BASE), .TO_CYC(TO_CYC)
    ) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans), .haddr(haddr),
        .hburst(hburst), .hsize(hsize), .hwdata(hwdata), .hwrite(hwrite),
        .hreadyin(hreadyin), .hrdata(hrdata), .hresp(hresp), .hready(hready),
        .ch_hsel(ch_hsel), .ch_htrans(ch_htrans), .ch_haddr(ch_haddr),
        .ch_hburst(ch_hburst), .ch_hsize(ch_hsize), .ch_hwdata(ch_hwdata),
        .ch_hwrite(ch_hwrite), .ch_hreadyin(ch_hreadyin), .ch_hrdata(ch_hrdata),
        .ch_hresp(ch_hresp), .ch_hready(ch_hready), .to_err(to_err), .hung(hung),
        .err_cnt(err_cnt)
    );

    always #5 hclk = ~hclk;
    assign hreadyin = hready;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        haddr  = $urandom;
        hwrite = 1'b0;
        hburst = 3'b000;
        hsize  = 3'b010;
    endtask

    // Active lane answers as told; idle lanes are ready unless the model holds them stuck
    task automatic set_lanes(input int act, input logic rdy, input logic [31:0] rd, input logic [1:0] rsp);
        for (int i = 0; i < N_CH; i++) begin
            if (i == act) begin
                ch_hready[i]          = rdy;
                ch_hrdata[i*DW +: DW] = rd;
                ch_hresp[i*2 +: 2]    = rsp;
            end else begin
                ch_hready[i]          = !hung_m[i];
                ch_hrdata[i*DW +: DW] = $urandom;
                ch_hresp[i*2 +: 2]    = 2'b01;
            end
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a, output int lane);
        longint off;
        off  = longint'(a) - longint'(BASE);
        lane = -1;
        if (off < 0 || off >= longint'(N_CH) * WIN) return 1'b0;
        lane = int'(off / WIN);
        return !hung_m[lane];
    endfunction

    task automatic err_cycles(input bit tmo);
        tick(); bus_idle(); set_lanes(-1, 1'b1, '0, 2'b00);
        @(negedge hclk);
        check_eq("err1_hready", hready, 0);
        check_eq("err1_hresp", hresp, 1);
        check_eq("err1_to_err", to_err, tmo);
        tick(); bus_idle(); set_lanes(-1, 1'b1, '0, 2'b00);
        @(negedge hclk);
        check_eq("err2_hready", hready, 1);
        check_eq("err2_hresp", hresp, 1);
        check_eq("err2_to_err", to_err, 0);
        if (err_m != 16'hFFFF) err_m++;
    endtask

    // One isolated transfer: address phase, then the data phase with `waits` slave wait states
    task automatic do_xfer(input logic [31:0] addr, input bit wr, input int waits, input logic [1:0] srsp);
        int              lane, ndata;
        bit              hit, tmo;
        logic [31:0]     wd, rd;
        logic [N_CH-1:0] exp_sel;
        wd      = $urandom;
        rd      = $urandom;
        hit     = model_hit(addr, lane);
        exp_sel = hit ? N_CH'(1 << lane) : '0;
        tmo     = hit && (waits >= int'(TO_CYC));
        tick();
        hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr;
        hburst = 3'b000; hsize = 3'b010; hwdata = $urandom;
        set_lanes(-1, 1'b1, '0, 2'b00);
        @(negedge hclk);
        check_eq("addr_hready", hready, 1);
        check_eq("ch_hsel", ch_hsel, exp_sel);
        check_eq("hung", hung, hung_m);
        check_eq("err_cnt", err_cnt, err_m);
        if (hit) check_eq("ch_haddr", ch_haddr[lane*AW +: AW], addr & 32'h3FF);
        if (hit) begin
            ndata = tmo ? int'(TO_CYC) : waits + 1;
            for (int c = 0; c < ndata; c++) begin
                tick(); bus_idle(); hwdata = wd;
                set_lanes(lane, c == waits, rd, (c == waits) ? srsp : 2'b00);
                @(negedge hclk);
                check_eq("dp_hready", hready, (c == waits));
                check_eq("dp_hresp", hresp, (c == waits) ? srsp : 2'b00);
                check_eq("dp_to_err", to_err, 0);
                if (c == waits && !wr) check_eq("hrdata", hrdata, rd);
                if (c == 0 && wr) check_eq("ch_hwdata", ch_hwdata[lane*DW +: DW], wd);
            end
            if (tmo) hung_m[lane] = 1'b1;
        end
        if (!hit || tmo) err_cycles(tmo);
    endtask

    task automatic release_hung();
        tick(); bus_idle(); hung_m = '0; set_lanes(-1, 1'b1, '0, 2'b00);
        @(negedge hclk);
        check_eq("rel_hready", hready, 1);
        tick(); bus_idle(); set_lanes(-1, 1'b1, '0, 2'b00);
        @(negedge hclk);
        check_eq("rel_hung", hung, hung_m);
    endtask

    // Back-to-back: ch0 read, miss, ch6 write, ch1 read with two wait states
    task automatic pipe_mix();
        logic [31:0] r0, r1, w6;
        r0 = $urandom; r1 = $urandom; w6 = $urandom;
        tick(); hsel = 1'b1; htrans = 2'b10; haddr = BASE + 32'h10; hwrite = 1'b0;
        set_lanes(-1, 1'b1, '0, 2'b00);
        @(negedge hclk);
        check_eq("pm0_sel", ch_hsel, 7'h01);
        check_eq("pm0_hready", hready, 1);
        tick(); haddr = 32'h6000_0000; set_lanes(0, 1'b1, r0, 2'b00);
        @(negedge hclk);
        check_eq("pm1_hready", hready, 1);
        check_eq("pm1_hrdata", hrdata, r0);
        check_eq("pm1_sel", ch_hsel, 0);
        tick(); haddr = BASE + 32'h1810; hwrite = 1'b1; set_lanes(-1, 1'b1, '0, 2'b00);
        @(negedge hclk);
        check_eq("pm2_hready", hready, 0);
        check_eq("pm2_hresp", hresp, 1);
        check_eq("pm2_sel", ch_hsel, 7'h40);
        tick();
        @(negedge hclk);
        check_eq("pm3_hready", hready, 1);
        check_eq("pm3_hresp", hresp, 1);
        tick(); haddr = BASE + 32'h408; hwrite = 1'b0; hwdata = w6;
        set_lanes(6, 1'b1, $urandom, 2'b00);
        @(negedge hclk);
        check_eq("pm4_hready", hready, 1);
        check_eq("pm4_hresp", hresp, 0);
        check_eq("pm4_wdata", ch_hwdata[6*DW +: DW], w6);
        check_eq("pm4_sel", ch_hsel, 7'h02);
        check_eq("pm4_haddr", ch_haddr[1*AW +: AW], 32'h008);
        for (int c = 0; c < 2; c++) begin
            tick(); bus_idle(); set_lanes(1, 1'b0, '0, 2'b00);
            @(negedge hclk);
            check_eq("pm_wait_hready", hready, 0);
        end
        tick(); set_lanes(1, 1'b1, r1, 2'b00);
        @(negedge hclk);
        check_eq("pm7_hready", hready, 1);
        check_eq("pm7_hrdata", hrdata, r1);
        err_m++;
        tick(); set_lanes(-1, 1'b1, '0, 2'b00);
        @(negedge hclk);
        check_eq("pm8_hready", hready, 1);
        check_eq("pm8_err_cnt", err_cnt, err_m);
    endtask

    task automatic reset_mid_read();
        release_hung();
        do_xfer(BASE + 32'h1008, 1'b0, 50, 2'b00);
        tick(); hsel = 1'b1; htrans = 2'b10; haddr = BASE + 32'h820; hwrite = 1'b0;
        set_lanes(-1, 1'b1, '0, 2'b00);
        @(negedge hclk);
        check_eq("rst_sel", ch_hsel, 7'h04);
        tick(); bus_idle(); set_lanes(2, 1'b0, '0, 2'b00);
        @(negedge hclk);
        check_eq("rst_wait_hready", hready, 0);
        tick(); hreset = 1'b1;
        tick();
        tick();
        tick(); hreset = 1'b0;
        hung_m = '0;
        err_m  = '0;
        @(negedge hclk);
        check_eq("rst_hready", hready, 1);
        check_eq("rst_hresp", hresp, 0);
        check_eq("rst_hrdata", hrdata, 0);
        check_eq("rst_hung", hung, 0);
        check_eq("rst_err_cnt", err_cnt, 0);
        check_eq("rst_to_err", to_err, 0);
        tick(); set_lanes(-1, 1'b1, '0, 2'b00);
        @(negedge hclk);
        check_eq("rst_after_hresp", hresp, 0);
        check_eq("rst_after_err_cnt", err_cnt, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        hung_m   = '0;
        err_m    = '0;
        hreset   = 1'b1;
        hwdata   = '0;
        bus_idle();
        set_lanes(-1, 1'b1, '0, 2'b00);
        repeat (2) @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        check_eq("init_hready", hready, 1);
        check_eq("init_hresp", hresp, 0);
        check_eq("init_hrdata", hrdata, 0);
        check_eq("init_hung", hung, 0);
        check_eq("init_err_cnt", err_cnt, 0);

        pipe_mix();
        do_xfer(32'h4000_0C04, 1'b1, 0, 2'b00);
        do_xfer(32'h4000_1C00, 1'b0, 0, 2'b00);
        do_xfer(32'h5000_0000, 1'b0, 0, 2'b00);
        do_xfer(32'h4000_1400, 1'b0, 100, 2'b00);
        do_xfer(32'h4000_1404, 1'b0, 0, 2'b00);
        release_hung();
        do_xfer(32'h4000_1408, 1'b0, 0, 2'b00);
        do_xfer(32'h4000_0800, 1'b0, int'(TO_CYC) - 1, 2'b00);

        for (int n = 0; n < 150; n++) begin
            int          r, w;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r <= 7)      a = BASE + 32'(r * 1024) + 32'($urandom_range(0, 255) * 4);
            else if (r == 8) a = 32'h5000_0000 + ($urandom & 32'h0FFF_FFFC);
            else             a = BASE - 32'd4;
            case ($urandom_range(0, 9))
                0:       w = int'(TO_CYC) + int'($urandom_range(0, 2));
                1:       w = int'(TO_CYC) - 1;
                default: w = int'($urandom_range(0, 3));
            endcase
            do_xfer(a, 1'($urandom_range(0, 1)), w, ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00);
            if ($urandom_range(0, 3) == 0) release_hung();
        end

        reset_mid_read();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rsp_s1_prep_ahb_dec.md
# rsp_s1_prep_ahb_dec

Parametrised single-master AHB-lite decoder and response multiplexer for the rsp_s1_prep register fabric. It fans one AHB slave port out to N_CH channel slaves, decoding channel windows of 2^CH_AW bytes above BASE_ADDR. It adds three behaviours to the fixed 7-channel interconnect:

- an internal default slave for unmapped addresses,
- a per-transfer wait-state timeout that aborts hung slaves with ERROR,
- sticky error status.

## Interface
- N_CH, 7: number of channel slaves (1..16)
- AHB_DW, 32: data width
- AHB_AW, 32: address width
- CH_AW, 10: byte-offset bits per channel window; ch_haddr mask = 2^CH_AW-1
- BASE_ADDR, 'h4000_0000: base of channel 0; must be aligned to 2^(CH_AW+SELW), where SELW = max(1, clog2(N_CH))
- TO_CYC, 256: wait-state limit per data phase; 0 disables the timeout
- hclk  in  1  clock
- hreset  in  1  synchronous, active-high reset
- hsel, htrans[1:0], haddr[AHB_AW-1:0], hburst[2:0], hsize[2:0], hwdata[AHB_DW-1:0], hwrite, hreadyin  in  -  upstream AHB address/data-phase signals
- hrdata  out  AHB_DW  read data of the current data phase
- hresp  out  2  response: 00 OKAY, 01 ERROR
- hready  out  1  transfer-complete
- ch_hsel  out  N_CH  per-channel select
- ch_htrans, ch_haddr, ch_hburst, ch_hsize, ch_hwdata, ch_hwrite, ch_hreadyin  out  N_CH×field  packed channel buses, lane i at [i*W +: W]
- ch_hrdata, ch_hresp, ch_hready  in  N_CH×field  packed channel responses
- to_err  out  1  one-cycle pulse on timeout abort
- hung  out  N_CH  sticky per-channel hung flag
- err_cnt  out  16  saturating count of ERROR responses issued by this block

## Operation

**Decode (combinational)**
- idx = haddr[CH_AW +: SELW].
- hit when haddr[AHB_AW-1 : CH_AW+SELW] equals the same bits of BASE_ADDR, idx < N_CH, and hung[idx] = 0.

**Fan-out**
- ch_hsel[i] = hsel & hit & (idx == i).
- htrans, hburst, hsize, hwrite and hwdata are broadcast to all lanes.
- ch_haddr lane = haddr & (2^CH_AW-1).
- ch_hreadyin = hreadyin on all lanes.

**Address-phase acceptance**
- Accepted when hsel & htrans[1] & hreadyin.
- On every hreadyin = 1 edge the data-phase register loads:
  - the channel index on an accepted hit,
  - DEF on an accepted miss,
  - NONE otherwise.

**FSM states:** IDLE, CH(k), ERR1, ERR2.
- IDLE: hready = 1, hresp = 00, hrdata = 0.
- CH(k): hrdata, hresp and hready are taken from lane k. The timeout counter increments each cycle that ch_hready[k] = 0 and clears on entry.
- Entry into CH(k) on a hit; into ERR1 on a miss (default slave).
- ERR1: hready = 0, hresp = 01. Always followed by ERR2.
- ERR2: hready = 1, hresp = 01. Next state is the newly loaded data-phase register.

**Timeout**
- When TO_CYC ≠ 0, the counter reaches TO_CYC-1, and ch_hready[k] is still 0 → go to ERR1, set hung[k], pulse to_err.
- The lane k response is ignored from then on.

**Hung channels**
- hung[k] clears on the first cycle ch_hready[k] = 1 while the FSM is not in CH(k).
- While hung[k] = 1, accesses to channel k miss and receive the default-slave ERROR.

**err_cnt**
- Increments once per ERR2 cycle; saturates at 16'hFFFF.
- Slave-originated ERROR responses are passed through but not counted.

## Timing
- Reset (synchronous, hreset = 1 at an hclk edge):
  - FSM returns to IDLE; timeout counter = 0; hung = 0; err_cnt = 0; to_err = 0.
  - Outputs: hready = 1, hresp = 00, hrdata = 0.
  - Channel outputs follow inputs combinationally (ch_hsel is 0 when hsel = 0).
- Reset mid-transfer aborts the transfer: no ERROR is issued and hung is not set.
- Address-to-slave latency is zero (combinational fan-out); response mux latency is zero.
- Default-slave and timeout ERROR responses both take exactly 2 cycles (ERR1, ERR2).
- Timeout: ERR1 begins TO_CYC cycles after the first wait-state cycle of the data phase.
- Back-to-back pipelining: a new address phase is accepted in the same cycle the current data phase completes, including during ERR2. There are no idle bubbles.
- Simultaneous ch_hready[k] = 1 and timeout expiry: the slave response wins. No timeout occurs and hung is not set.
- BUSY and IDLE htrans never change data-phase state beyond loading NONE.

## Test plan
1. **Reset.** Assert hreset for 3 cycles mid-read to channel 2. Required: hready = 1, hresp = 00, hrdata = 0, hung = 0, err_cnt = 0 on the cycle after the reset edge.
2. **Mapped write.** Write 0xA5A5_0001 to 0x4000_0C04 (N_CH = 7, CH_AW = 10). Required: ch_hsel = 7'b000_1000, ch_haddr lane 3 = 0x004, ch_hwdata lane 3 = 0xA5A5_0001 in the data phase, hresp = 00.
3. **Unmapped read.** Read 0x4000_1C00 (idx = 7) and then 0x5000_0000. Required: ch_hsel = 0 for both; each returns a 2-cycle ERROR (hready 0 then 1, hresp = 01); err_cnt = 2.
4. **Timeout.** TO_CYC = 8; channel 5 holds ch_hready[5] = 0 indefinitely. Required: ERR1 starts 8 cycles after the first wait-state cycle; to_err pulses for one cycle; hung[5] = 1. A following access to channel 5 gets a default ERROR with ch_hsel[5] = 0.
5. **Drain.** After scenario 4, raise ch_hready[5] for one cycle. Required: hung[5] = 0 on the next cycle; the next read of channel 5 returns its ch_hrdata with hresp = 00.
6. **Pipelined mix.** Send four back-to-back NONSEQ transfers: ch0 read, miss, ch6 write, ch1 read (ch1 inserts 2 wait states). Required: responses arrive in order with no idle cycles between data phases; hrdata correct per lane; err_cnt increments by 1.
